data_memory_responder: RTL
==========================

// Module: data_memory_responder
// PURPOSE
//   Memory-side responder for the core's data-memory load/store port: accepts one
//   doubleword request at a time over a valid/ready channel and returns a response
//   (read data or write ack, plus error flag) over a second valid/ready channel.
//   Replaces the core-internal data_memory array; models fixed multi-cycle access
//   latency so the core's stall logic can be exercised.
// PARAMETERS
//   DEPTH    1024  number of 64-bit words; power of two, >= 2
//   LATENCY  2     edges from request accept to rsp_valid high; >= 1
// PORTS
//   clock       in   1   single clock, all logic on posedge
//   reset       in   1   synchronous, active-high
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept; high only in IDLE
//   req_write   in   1   1 = store, 0 = load
//   req_addr    in   64  byte address
//   req_wdata   in   64  store data
//   rsp_valid   out  1   response present
//   rsp_ready   in   1   core accepts response
//   rsp_rdata   out  64  load data; 0 for stores and errors
//   rsp_err     out  1   invalid address (invMemAddr equivalent)
// BEHAVIOUR
// - Reset (sync, clock edge with reset=1): state=IDLE, req_ready=1 after reset
//   deasserts, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Memory array NOT cleared.
// - Reset overrides everything, including mid-BUSY: pending request dropped; a store
//   not yet committed is never written.
// - FSM: IDLE -> BUSY on accept (req_valid & req_ready); LATENCY=1 goes IDLE -> RESP.
//   BUSY counts down LATENCY-1 cycles, then -> RESP. RESP -> IDLE on rsp_valid & rsp_ready.
// - Accept edge latches req_write, req_addr, req_wdata; later req_* changes ignored.
// - Address check on latched addr: err = (addr[2:0] != 0) | ((addr >> 3) >= DEPTH).
//   Word index = addr[$clog2(DEPTH)+2:3].
// - Commit edge (edge entering RESP, exactly LATENCY edges after accept):
//   load: rsp_rdata <= mem[idx] (0 if err); store: mem[idx] <= wdata unless err,
//   rsp_rdata <= 0; rsp_err <= err; rsp_valid <= 1.
// - rsp_valid/rsp_rdata/rsp_err held stable while rsp_ready=0 (any number of cycles).
// - Handshake edge: rsp_valid <= 0, rsp_rdata <= 0, rsp_err <= 0; req_ready=1 the
//   following cycle. Max throughput: one request per LATENCY+1 cycles with rsp_ready=1.
// - req_ready is combinational from state (IDLE only); no request accepted in BUSY/RESP.
// - Invalid-address requests never modify memory and still produce exactly one response.
// - Counter width $clog2(LATENCY+1); no wrap because it is reloaded on every accept.
// TESTING
//   1. Store addr 0x10 data 0xDEADBEEF_CAFEF00D, then load 0x10 -> rsp_valid exactly
//      2 edges after each accept; load rsp_rdata=0xDEADBEEF_CAFEF00D, rsp_err=0.
//   2. Load addr 0x14 (misaligned) -> rsp_err=1, rsp_rdata=0; store to 0x14 leaves
//      words 0x10 and 0x18 unchanged.
//   3. Store addr 0x2000 (index 1024, DEPTH=1024) -> rsp_err=1; load 0x1FF8 -> err=0.
//   4. Hold rsp_ready=0 for 3 cycles in RESP -> rsp_* stable, req_ready=0, second
//      req_valid ignored; rsp_ready=1 -> handshake, req_ready=1 next cycle.
//   5. Assert reset one cycle after accepting store to 0x20 -> next cycle IDLE,
//      rsp_valid=0; subsequent load 0x20 returns the pre-store value.
//   6. LATENCY=1 build, back-to-back loads with rsp_ready=1 -> one response per
//      2 cycles, data correct for each.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data-memory responder: one 64-bit load/store in flight, fixed access latency,
// request and response on independent valid/ready channels.
module data_memory_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(LATENCY + 1);
    localparam int LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          lat_write;
    logic [63:0]   lat_addr;
    logic [63:0]   lat_wdata;
    logic [63:0]   mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          cur_write;
    logic          cur_err;
    logic [63:0]   cur_addr;
    logic [63:0]   cur_wdata;
    logic [AW-1:0] cur_idx;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // With a single-cycle latency the commit happens on the accept edge itself,
    // so the request fields are taken straight from the port instead of the latch.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
        cur_err = (cur_addr[2:0] != 3'd0) || ((cur_addr >> 3) >= 64'(DEPTH));
        cur_idx = cur_addr[AW+2:3];
        commit  = (LATENCY == 1) ? accept : ((state == BUSY) && (count == '0));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        count     <= CW'(LOAD);
                        state     <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (count != '0) count <= count - 1'b1;
                    else             state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_write || cur_err) ? 64'd0 : mem[cur_idx];
            end
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && commit && cur_write && !cur_err)
            mem[cur_idx] <= cur_wdata;
    end

endmodule
